tohost_monitor: RTL and testbench
=================================

# tohost_monitor

Observes the core's data-memory write port during a riscv-tests run (e.g. rv32ui-p-lbu) and decodes the `tohost` handshake into a pass/fail/timeout result. It is the consumer end of the program-load path: the bench preloads memory and starts the core, and this block reports how the test ended. It sits beside `Core`, taps the memory write bus, and hands one result record to the bench through a valid/ready handshake. Its watchdog replaces the bench's fixed tick budget.

## Interface
- `XLEN`, 32: data and address width.
- `TOHOST_ADDR`, 32'h0000_1000: byte address of the `tohost` word.
- `TIMEOUT`, 5000: maximum RUN cycles before a timeout result. Must be ≥1.
- `CNT_W`, 32: cycle-counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins monitoring.
- `mem_we` in 1: core data-memory write enable.
- `mem_addr` in XLEN: write byte address.
- `mem_wdata` in XLEN: write data.
- `mem_wstrb` in XLEN/8: byte-lane strobes.
- `busy` out 1: high in RUN and REPORT.
- `res_valid` out 1: a result is available.
- `res_ready` in 1: the bench accepts the result.
- `res_pass` out 1: the test passed.
- `res_timeout` out 1: the watchdog expired.
- `res_testnum` out XLEN-1: failing test number, `tohost[XLEN-1:1]`.
- `res_cycles` out CNT_W: number of RUN cycles consumed.

## Operation
- FSM states: IDLE, RUN, REPORT.
- IDLE:
  - `start`=1 → RUN, and the counter clears to 0.
  - Bus activity is ignored.
- RUN: every cycle the counter increments, saturating at all-ones.
- Hit: `mem_we` && `mem_addr`==TOHOST_ADDR && `mem_wstrb` all ones && `mem_wdata[0]`==1.
  - Latch `res_pass` = (`mem_wdata`==1).
  - Latch `res_testnum` = `mem_wdata[XLEN-1:1]`.
  - Latch `res_timeout`=0.
  - Go to REPORT.
- Ignored writes, which stay in RUN:
  - any write to TOHOST_ADDR with `wdata[0]`=0 (syscall encoding);
  - a partial-strobe write to TOHOST_ADDR;
  - any write to another address.
- Timeout: counter reaches TIMEOUT in RUN without a hit → REPORT with `res_timeout`=1, `res_pass`=0, `res_testnum`=0.
- A hit and a timeout in the same cycle → the hit wins (`res_timeout`=0).
- REPORT:
  - `res_valid`=1; all `res_*` outputs are held stable.
  - `res_valid && res_ready` at a clock edge → IDLE; `res_valid` drops the next cycle.
  - Result fields keep their last values in IDLE.
- `start` in RUN or REPORT is ignored. No restart without the handshake.
- `res_cycles` counts RUN cycles up to and including the terminating cycle.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `busy`, `res_valid`, `res_pass`, `res_timeout` = 0; `res_testnum`, `res_cycles` = 0. Reset takes effect immediately in any state, including mid-RUN.
- `start` sampled at edge T → `busy`=1 from T+1, and the first RUN cycle is T+1.
- Hit sampled at edge H → `res_valid`=1 from H+1, and `res_cycles` = H−T.
- Hit in the first RUN cycle → `res_cycles`=1.
- Timeout: RUN lasts exactly TIMEOUT cycles, so `res_cycles`=TIMEOUT and `res_valid` rises the cycle after.
- `res_ready` may be held high permanently, giving a one-cycle REPORT.
- `res_ready` outside REPORT has no effect.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `tohost_pkg`:
  - state enum (IDLE/RUN/REPORT);
  - default TOHOST_ADDR;
  - pass encoding (32'h1);
  - result record type {pass, timeout, testnum, cycles}.
- One sub-module, `sat_counter`: CNT_W wide, with clear, enable and saturate, plus an output that compares the count against a limit.
- Top level: FSM, hit decode, result registers.
- Instantiated by the bench next to `Core`, wired to its memory write port.

## Test plan
- Pass run: TIMEOUT=100, `start` at T, full-word write 32'h1 to 0x1000 at T+10 → `res_valid` at T+11 with pass=1, timeout=0, testnum=0, cycles=10.
- Fail run: write 32'h7 to 0x1000 → pass=0, testnum=3. Earlier writes of 32'h6 (bit0=0) and a strobe-4'b0001 write of 32'h1 → no result.
- Timeout: TIMEOUT=20, no hit → `res_valid` 21 cycles after the start edge with timeout=1, cycles=20. A hit on the final RUN cycle instead → pass result, timeout=0.
- Handshake: `res_ready` low for 5 cycles in REPORT → outputs stable and `start` ignored. `res_ready` high → IDLE next cycle, and a new `start` runs with cycles restarting at 1.
- Reset mid-RUN: assert `rst`=0 between edges → `busy` low immediately. After release, a hit without `start` → no `res_valid`.

Source files
------------

// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost monitor: FSM states, the tohost address,
// the pass encoding and the result record.
package tohost_pkg;

    localparam int TH_XLEN  = 32;
    localparam int TH_CNT_W = 32;

    localparam logic [TH_XLEN-1:0] TOHOST_ADDR_DEF = 32'h0000_1000;
    localparam logic [TH_XLEN-1:0] PASS_CODE       = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    typedef struct packed {
        logic                  pass;
        logic                  timeout;
        logic [TH_XLEN-2:0]    testnum;
        logic [TH_CNT_W-1:0]   cycles;
    } result_t;

endpackage

// File: rtl/tohost_monitor_if.sv
// Memory write tap, start pulse and result handshake between the bench and the monitor.
interface tohost_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic                start;
    logic                mem_we;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic                busy;
    logic                res_valid;
    logic                res_ready;
    logic                res_pass;
    logic                res_timeout;
    logic [XLEN-2:0]     res_testnum;
    logic [CNT_W-1:0]    res_cycles;

    modport master (
        output start, mem_we, mem_addr, mem_wdata, mem_wstrb, res_ready,
        input  busy, res_valid, res_pass, res_timeout, res_testnum, res_cycles
    );

    modport slave (
        input  start, mem_we, mem_addr, mem_wdata, mem_wstrb, res_ready,
        output busy, res_valid, res_pass, res_timeout, res_testnum, res_cycles
    );
endinterface

// File: rtl/tohost_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes the next count and whether
// that next count equals the supplied limit.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o,
    output logic             at_limit_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i && !(&count_q))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign at_limit_o   = (count_d == limit_i);
endmodule

// File: rtl/tohost_monitor.sv
// Watches the data-memory write port for the riscv-tests tohost handshake and
// reports pass/fail/timeout through a valid/ready result record.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter int              XLEN        = TH_XLEN,
    parameter logic [XLEN-1:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
    parameter int              TIMEOUT     = 5000,
    parameter int              CNT_W       = TH_CNT_W
) (
    input logic        clk,
    input logic        rst,
    tohost_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    result_t          res_q, res_d;
    logic             cnt_clr, cnt_en, at_limit, hit;
    logic [CNT_W-1:0] cnt_q, cnt_next;

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (cnt_clr),
        .en_i         (cnt_en),
        .limit_i      (LIMIT),
        .count_o      (cnt_q),
        .count_next_o (cnt_next),
        .at_limit_o   (at_limit)
    );

    // Only full-word writes with bit0 set terminate; bit0=0 is the syscall encoding.
    assign hit = bus.mem_we && (bus.mem_addr == TOHOST_ADDR) &&
                 (&bus.mem_wstrb) && bus.mem_wdata[0];

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (hit) begin
                    state_d       = REPORT;
                    res_d.pass    = (bus.mem_wdata == XLEN'(PASS_CODE));
                    res_d.timeout = 1'b0;
                    res_d.testnum = bus.mem_wdata[XLEN-1:1];
                    res_d.cycles  = cnt_next;
                end else if (at_limit) begin
                    state_d       = REPORT;
                    res_d.pass    = 1'b0;
                    res_d.timeout = 1'b1;
                    res_d.testnum = '0;
                    res_d.cycles  = cnt_next;
                end
            end
            REPORT: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.res_valid   = (state_q == REPORT);
    assign bus.res_pass    = res_q.pass;
    assign bus.res_timeout = res_q.timeout;
    assign bus.res_testnum = res_q.testnum;
    assign bus.res_cycles  = res_q.cycles;
endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: pass, fail, timeout, handshake, restart and reset.
module tb_tohost_monitor;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    tohost_monitor_if #(.XLEN(32), .CNT_W(32)) bus ();

    tohost_monitor #(
        .XLEN        (32),
        .TOHOST_ADDR (32'h0000_1000),
        .TIMEOUT     (20),
        .CNT_W       (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        bus.mem_wstrb = strb;
        tick();
        bus.mem_we    = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 0; bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
        bus.mem_wstrb = 0; bus.res_ready = 0;
        tick(); tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", bus.busy); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.res_valid); end
        total++; if (bus.res_pass !== 1'b0) begin bad++; $display("FAIL rst_pass got=%0b want=0", bus.res_pass); end
        total++; if (bus.res_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0b want=0", bus.res_timeout); end
        total++; if (bus.res_testnum !== 31'd0) begin bad++; $display("FAIL rst_testnum got=%0d want=0", bus.res_testnum); end
        total++; if (bus.res_cycles !== 32'd0) begin bad++; $display("FAIL rst_cycles got=%0d want=0", bus.res_cycles); end
        rst = 1'b1;
        tick();
        do_write(32'h1000, 32'h1, 4'hF);  // idle bus activity must be ignored
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL idle_ignore got=%0b want=0", bus.res_valid); end
    endtask

    task automatic test_pass();
        do_start();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL pass_busy got=%0b want=1", bus.busy); end
        for (int i = 0; i < 9; i++) tick();
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL pass_early got=%0b want=0", bus.res_valid); end
        do_write(32'h1000, 32'h1, 4'hF);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%0b want=1", bus.res_valid); end
        total++; if (bus.res_pass !== 1'b1) begin bad++; $display("FAIL pass_pass got=%0b want=1", bus.res_pass); end
        total++; if (bus.res_timeout !== 1'b0) begin bad++; $display("FAIL pass_timeout got=%0b want=0", bus.res_timeout); end
        total++; if (bus.res_testnum !== 31'd0) begin bad++; $display("FAIL pass_testnum got=%0d want=0", bus.res_testnum); end
        total++; if (bus.res_cycles !== 32'd10) begin bad++; $display("FAIL pass_cycles got=%0d want=10", bus.res_cycles); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL pass_ack got=%0b want=0", bus.res_valid); end
        total++; if (bus.res_cycles !== 32'd10) begin bad++; $display("FAIL pass_hold_idle got=%0d want=10", bus.res_cycles); end
    endtask

    task automatic test_fail_and_handshake();
        do_start();
        tick(); tick();
        do_write(32'h1000, 32'h6, 4'hF);   // syscall encoding
        do_write(32'h1000, 32'h1, 4'h1);   // partial strobe
        do_write(32'h1004, 32'h7, 4'hF);   // other address
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL fail_ignored got=%0b want=0", bus.res_valid); end
        do_write(32'h1000, 32'h7, 4'hF);
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL fail_valid got=%0b want=1", bus.res_valid); end
        total++; if (bus.res_pass !== 1'b0) begin bad++; $display("FAIL fail_pass got=%0b want=0", bus.res_pass); end
        total++; if (bus.res_testnum !== 31'd3) begin bad++; $display("FAIL fail_testnum got=%0d want=3", bus.res_testnum); end
        total++; if (bus.res_cycles !== 32'd6) begin bad++; $display("FAIL fail_cycles got=%0d want=6", bus.res_cycles); end
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1;
            tick();
            total++; if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1) begin
                bad++; $display("FAIL hs_hold_valid got=%0b/%0b want=1/1", bus.res_valid, bus.busy); end
            total++; if (bus.res_testnum !== 31'd3 || bus.res_cycles !== 32'd6 || bus.res_pass !== 1'b0) begin
                bad++; $display("FAIL hs_hold_data got=%0d/%0d want=3/6", bus.res_testnum, bus.res_cycles); end
        end
        bus.start = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        total++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL hs_release got=%0b/%0b want=0/0", bus.res_valid, bus.busy); end
    endtask

    task automatic test_back_to_back();
        do_start();
        do_write(32'h1000, 32'h1, 4'hF);   // hit in first RUN cycle
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b want=1", bus.res_valid); end
        total++; if (bus.res_cycles !== 32'd1) begin bad++; $display("FAIL b2b_cycles got=%0d want=1", bus.res_cycles); end
        total++; if (bus.res_pass !== 1'b1) begin bad++; $display("FAIL b2b_pass got=%0b want=1", bus.res_pass); end
        bus.res_ready = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        // res_ready stays high: one-cycle REPORT
        do_start();
        for (int i = 0; i < 19; i++) tick();
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL to_early got=%0b want=0", bus.res_valid); end
        tick();
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL to_valid got=%0b want=1", bus.res_valid); end
        total++; if (bus.res_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%0b want=1", bus.res_timeout); end
        total++; if (bus.res_pass !== 1'b0 || bus.res_testnum !== 31'd0) begin
            bad++; $display("FAIL to_fields got=%0b/%0d want=0/0", bus.res_pass, bus.res_testnum); end
        total++; if (bus.res_cycles !== 32'd20) begin bad++; $display("FAIL to_cycles got=%0d want=20", bus.res_cycles); end
        tick();
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL to_oneshot got=%0b want=0", bus.res_valid); end
    endtask

    task automatic test_final_hit();
        do_start();
        for (int i = 0; i < 19; i++) tick();
        do_write(32'h1000, 32'h1, 4'hF);   // hit on the same edge the watchdog expires
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL fh_valid got=%0b want=1", bus.res_valid); end
        total++; if (bus.res_timeout !== 1'b0) begin bad++; $display("FAIL fh_timeout got=%0b want=0", bus.res_timeout); end
        total++; if (bus.res_pass !== 1'b1) begin bad++; $display("FAIL fh_pass got=%0b want=1", bus.res_pass); end
        total++; if (bus.res_cycles !== 32'd20) begin bad++; $display("FAIL fh_cycles got=%0d want=20", bus.res_cycles); end
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        do_start();
        tick(); tick(); tick();
        #2 rst = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%0b want=0", bus.busy); end
        total++; if (bus.res_cycles !== 32'd0) begin bad++; $display("FAIL mr_cycles got=%0d want=0", bus.res_cycles); end
        tick();
        rst = 1'b1;
        tick();
        do_write(32'h1000, 32'h1, 4'hF);
        tick();
        total++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL mr_nostart got=%0b/%0b want=0/0", bus.res_valid, bus.busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_pass();
        test_fail_and_handshake();
        test_back_to_back();
        test_timeout();
        test_final_hit();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
